// File: rtl/relu_rr_sched.sv
// rtl/relu_rr_sched.sv - round-robin time-shared ReLU over NUM_CH streams with per-frame counting
// One registered output stage, tagged with channel index; done pulses once the frame has drained.
module relu_rr_sched #(
  parameter int BIT_WIDTH = 32,
  parameter int NUM_CH    = 4,
  parameter int FRAME_LEN = 576,
  localparam int CH_W  = $clog2(NUM_CH),
  localparam int CNT_W = $clog2(FRAME_LEN + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_CH-1:0]           in_valid,
  input  logic [NUM_CH*BIT_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]           in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BIT_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]             out_ch,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CH_W-1:0]  CH_MAX   = CH_W'(NUM_CH - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt [NUM_CH];
  logic [CH_W-1:0]      ptr;
  logic [CH_W-1:0]      gnt;
  logic                 gnt_vld;
  logic                 gnt_last;
  logic                 others_done;
  logic                 slot_free;
  logic                 xfer;
  logic [NUM_CH-1:0]    elig;
  logic [BIT_WIDTH-1:0] gnt_data;

  // Channels that already delivered FRAME_LEN elements drop out of arbitration.
  always_comb begin
    elig = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      elig[c] = in_valid[c] && (cnt[c] < CNT_FULL);
    end
  end

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!gnt_vld && elig[c] && (((int'(ptr) + i) % NUM_CH) == c)) begin
          gnt_vld = 1'b1;
          gnt     = CH_W'(c);
        end
      end
    end
  end

  // others_done tells whether the granted element is the last one of the whole frame.
  always_comb begin
    gnt_data    = '0;
    gnt_last    = 1'b0;
    others_done = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt == CH_W'(c)) begin
        gnt_data = in_data[c*BIT_WIDTH +: BIT_WIDTH];
        gnt_last = (cnt[c] == CNT_LAST);
      end else if (cnt[c] != CNT_FULL) begin
        others_done = 1'b0;
      end
    end
  end

  assign slot_free = !out_valid || out_ready;
  assign xfer      = (state == S_RUN) && gnt_vld && slot_free;
  assign busy      = (state != S_IDLE);

  always_comb begin
    in_ready = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      in_ready[c] = xfer && (gnt == CH_W'(c));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c] <= '0;
      end
    end else begin
      done <= 1'b0;

      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data[BIT_WIDTH-1] ? '0 : gnt_data;
        out_ch    <= gnt;
        out_last  <= gnt_last;
        ptr       <= (gnt == CH_MAX) ? '0 : gnt + CH_W'(1);
        for (int c = 0; c < NUM_CH; c++) begin
          if (gnt == CH_W'(c)) begin
            cnt[c] <= cnt[c] + CNT_W'(1);
          end
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            ptr   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
              cnt[c] <= '0;
            end
          end
        end
        S_RUN: begin
          if (xfer && gnt_last && others_done) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (slot_free) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_rr_sched.sv
// tb/tb_relu_rr_sched.sv - directed self-checking bench for relu_rr_sched
module tb_relu_rr_sched;
  localparam int BW  = 32;
  localparam int NCH = 4;
  localparam int FL  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [NCH-1:0]  in_valid;
  logic [NCH*BW-1:0] in_data;
  logic [NCH-1:0]  in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [BW-1:0]   out_data;
  logic [1:0]      out_ch;
  logic            out_last;
  logic            busy;
  logic            done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] lane_v [4];
  logic [31:0] lane_e [4];
  logic [31:0] sl_in  [4];
  logic [31:0] sl_exp [4];
  int          cnt_o  [4];

  relu_rr_sched #(.BIT_WIDTH(BW), .NUM_CH(NCH), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_lane(input int c, input logic [31:0] v);
    in_data[c*BW +: BW] = v;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  k;
    int  total;
    int  n_done;
    bit  seen;
    logic [31:0] h_data;
    logic [1:0]  h_ch;
    logic        h_last;

    lane_v[0] = 32'h0000_0001; lane_e[0] = 32'h0000_0001;
    lane_v[1] = 32'h7FFF_FFFF; lane_e[1] = 32'h7FFF_FFFF;
    lane_v[2] = 32'h8000_0000; lane_e[2] = 32'h0000_0000;
    lane_v[3] = 32'hFFFF_FFFD; lane_e[3] = 32'h0000_0000;
    sl_in[0] = 32'd5;          sl_exp[0] = 32'd5;
    sl_in[1] = 32'hFFFF_FFF9;  sl_exp[1] = 32'd0;
    sl_in[2] = 32'd0;          sl_exp[2] = 32'd0;
    sl_in[3] = 32'h8000_0000;  sl_exp[3] = 32'd0;

    // reset state
    rst = 1'b1; start = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    in_valid = 4'hF;
    for (int c = 0; c < 4; c++) set_lane(c, lane_v[c]);
    @(negedge clk);
    check("idle_in_ready", in_ready, 0);
    check("idle_out_valid", out_valid, 0);

    // full frame, all lanes valid
    do_start();
    #1 check("ff_first_rdy", in_ready, 4'b0001);
    k = 0;
    for (int cyc = 0; cyc < 40 && k < 16; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        check("ff_ch", out_ch, k % 4);
        check("ff_data", out_data, lane_e[k % 4]);
        check("ff_last", out_last, (k >= 12));
        k++;
      end
    end
    check("ff_count", k, 16);
    check("ff_busy_last", busy, 1);
    check("ff_done_early", done, 0);
    @(negedge clk);
    check("ff_done", done, 1);
    check("ff_busy_fall", busy, 0);
    @(negedge clk);
    check("ff_done_pulse", done, 0);

    // single lane on channel 2, then ch0 alone, then fairness between 1 and 3
    in_valid = 4'b0100;
    set_lane(2, sl_in[0]);
    do_start();
    for (int i = 0; i < 4; i++) begin
      set_lane(2, sl_in[i]);
      #1 check("sl_rdy", in_ready, 4'b0100);
      @(negedge clk);
      check("sl_valid", out_valid, 1);
      check("sl_data", out_data, sl_exp[i]);
      check("sl_ch", out_ch, 2);
      check("sl_last", out_last, (i == 3));
    end
    #1 check("sl_mask", in_ready, 0);
    in_valid = 4'b0001;
    set_lane(0, lane_v[0]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("c0_valid", out_valid, 1);
      check("c0_ch", out_ch, 0);
    end
    in_valid = 4'b1011;
    #1 check("fr_first_rdy", in_ready, 4'b0010);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("fr_valid", out_valid, 1);
      check("fr_ch", out_ch, (i % 2) ? 3 : 1);
      check("fr_last", out_last, (i >= 6));
      check("fr_ch0_masked", in_ready[0], 0);
    end
    @(negedge clk);
    check("fr_done", done, 1);

    // back-pressure mid-stream, with a stray start while running
    in_valid = 4'hF;
    for (int c = 0; c < 4; c++) begin
      set_lane(c, lane_v[c]);
      cnt_o[c] = 0;
    end
    out_ready = 1'b1;
    do_start();
    seen = 1'b0;
    h_data = '0; h_ch = '0; h_last = 1'b0;
    for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      if (cyc == 2) start = 1'b1;
      if (cyc == 3) begin
        start = 1'b0;
        check("bp_busy_after_start", busy, 1);
      end
      if (cyc == 5) begin
        check("bp_valid_before", out_valid, 1);
        h_data = out_data; h_ch = out_ch; h_last = out_last;
        out_ready = 1'b0;
      end
      if (cyc >= 6 && cyc <= 10) begin
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data", out_data, h_data);
        check("bp_hold_ch", out_ch, h_ch);
        check("bp_hold_last", out_last, h_last);
        check("bp_in_ready", in_ready, 0);
      end
      if (cyc == 10) out_ready = 1'b1;
      if (!seen && out_valid && out_ready) cnt_o[out_ch]++;
    end
    check("bp_done_seen", seen, 1);
    total = 0;
    for (int c = 0; c < 4; c++) begin
      check("bp_per_ch", cnt_o[c], 4);
      total += cnt_o[c];
    end
    check("bp_total", total, 16);

    // reset mid-frame, then a fresh frame
    do_start();
    repeat (6) @(negedge clk);
    check("mr_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("mr_out_valid", out_valid, 0);
    check("mr_out_data", out_data, 0);
    check("mr_out_ch", out_ch, 0);
    check("mr_out_last", out_last, 0);
    check("mr_in_ready", in_ready, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) cnt_o[c] = 0;
    n_done = 0;
    do_start();
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (out_valid) cnt_o[out_ch]++;
      if (done) n_done++;
    end
    for (int c = 0; c < 4; c++) check("mr_per_ch", cnt_o[c], 4);
    check("mr_done_once", n_done, 1);
    check("mr_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
